// File: rtl/parity_pipe.sv
// Pipelined parity generator/checker: registered XOR tree, LPS levels per stage, valid/ready flow.
// Optional saturating mismatch counter when PARITY_ERR_CNT_EN is defined.
module parity_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LPS   = 2
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             in_chk,
    input  logic             in_odd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [15:0]      err_cnt
);

    localparam int unsigned LEVELS  = $clog2(WIDTH);
    localparam int unsigned STG_RAW = (LEVELS + LPS - 1) / LPS;
    localparam int unsigned STAGES  = (STG_RAW < 1) ? 1 : STG_RAW;
    localparam int unsigned PAD     = 1 << LEVELS;

    // One stage's worth of pairwise XOR levels; live bits stay packed at the bottom.
    function automatic logic [PAD-1:0] xor_levels(input logic [PAD-1:0] v);
        logic [PAD-1:0] cur;
        logic [PAD-1:0] nxt;
        cur = v;
        for (int unsigned l = 0; l < LPS; l++) begin
            nxt = '0;
            for (int unsigned k = 0; k < PAD / 2; k++) begin
                nxt[k] = cur[2*k] ^ cur[2*k+1];
            end
            cur = nxt;
        end
        return cur;
    endfunction

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] rdy;
    logic [PAD-1:0]    sum_q [STAGES];
    logic              chk_q [STAGES];
    logic              odd_q [STAGES];
    logic              ipar_q[STAGES];

    logic [PAD-1:0]    din   [STAGES];
    logic              vin   [STAGES];
    logic              cin   [STAGES];
    logic              oin   [STAGES];
    logic              pin   [STAGES];
    logic              full;
    logic              last_par;

    // A stage can load if it is empty or every stage downstream of it can shift.
    always_comb begin
        full = 1'b0;
        rdy  = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            full = 1'b1;
            for (int unsigned j = i; j < STAGES; j++) begin
                full = full & valid_q[j];
            end
            rdy[i] = out_ready | ~full;
        end
    end

    always_comb begin
        din[0]            = '0;
        din[0][WIDTH-1:0] = in_data;
        vin[0]            = in_valid;
        cin[0]            = in_chk;
        oin[0]            = in_odd;
        pin[0]            = in_par;
        for (int unsigned i = 1; i < STAGES; i++) begin
            din[i] = sum_q[i-1];
            vin[i] = valid_q[i-1];
            cin[i] = chk_q[i-1];
            oin[i] = odd_q[i-1];
            pin[i] = ipar_q[i-1];
        end
    end

    // Only the low 2^LPS bits of the final stage input can be nonzero, so this is at most LPS levels deep.
    assign last_par = ^din[STAGES-1];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i + 1 < STAGES; i++) begin
            if (rdy[i] && vin[i]) begin
                sum_q[i]  <= xor_levels(din[i]);
                chk_q[i]  <= cin[i];
                odd_q[i]  <= oin[i];
                ipar_q[i] <= pin[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            valid_q <= '0;
            out_par <= 1'b0;
            out_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    valid_q[i] <= vin[i];
                end
            end
            if (rdy[STAGES-1] && vin[STAGES-1]) begin
                out_par <= last_par ^ oin[STAGES-1];
                out_err <= cin[STAGES-1] & ((last_par ^ oin[STAGES-1]) != pin[STAGES-1]);
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[STAGES-1];

`ifdef PARITY_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            err_cnt_q <= '0;
        end else if (cnt_clr) begin
            err_cnt_q <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule
